// File: rtl/uart_baud_sched.sv
// uart_baud_sched: programmable baud-tick scheduler.
// Produces an oversample strobe (os_tick) and a bit strobe (bit_tick) as
// clock enables in the clk_in domain. A divisor offered in RUN is held in
// pend_div and committed on the next bit boundary (PEND state). The RX engine
// can restart the phase with resync. Dropping en returns to IDLE and commits
// any pending divisor, so a write is never lost.
//
// Config handshake: a divisor is transferred on every rising edge where
// cfg_valid && cfg_ready. cfg_ready depends only on state (low in PEND), so
// the source may hold cfg_valid for as long as it needs to.
module uart_baud_sched #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned DEFAULT_DIV = 27,
    localparam int unsigned OS_W       = $clog2(OVERSAMPLE)
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    input  logic             resync,
    output logic             os_tick,
    output logic             bit_tick,
    output logic [OS_W-1:0]  phase,
    output logic [CNT_W-1:0] div_cur,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             os_tick_q, os_tick_d;
    logic             bit_tick_q, bit_tick_d;

    logic             cfg_acc;
    logic [CNT_W-1:0] cfg_clamped;
    logic [CNT_W-1:0] div_m1;

    // A zero divisor is stored as 1 so div_q-1 can never underflow.
    assign cfg_ready   = (state_q != PEND);
    assign cfg_acc     = cfg_valid && cfg_ready;
    assign cfg_clamped = (cfg_div == '0) ? CNT_W'(1) : cfg_div;
    assign div_m1      = div_q - CNT_W'(1);

    assign os_tick   = os_tick_q;
    assign bit_tick  = bit_tick_q;
    assign phase     = os_cnt_q;
    assign div_cur   = div_q;
    assign dbg_state = state_q;

    // State register and counters; async reset returns everything to defaults.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            os_cnt_q   <= '0;
            div_q      <= CNT_W'(DEFAULT_DIV);
            pend_q     <= '0;
            os_tick_q  <= 1'b0;
            bit_tick_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            os_cnt_q   <= os_cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            os_tick_q  <= os_tick_d;
            bit_tick_q <= bit_tick_d;
        end
    end

    // Next-state: priority is en=0, then resync, then the divisor wrap.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        os_cnt_d   = os_cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        os_tick_d  = 1'b0;
        bit_tick_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d    = '0;
                os_cnt_d = '0;
                if (cfg_acc) begin
                    div_d = cfg_clamped;
                end
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN, PEND: begin
                if (!en) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    os_cnt_d = '0;
                    if (state_q == PEND) begin
                        div_d = pend_q;
                    end else if (cfg_acc) begin
                        div_d = cfg_clamped;
                    end
                end else begin
                    if (state_q == RUN && cfg_acc) begin
                        pend_d  = cfg_clamped;
                        state_d = PEND;
                    end
                    if (resync) begin
                        cnt_d    = '0;
                        os_cnt_d = '0;
                    end else if (cnt_q == div_m1) begin
                        cnt_d     = '0;
                        os_tick_d = 1'b1;
                        os_cnt_d  = os_cnt_q + OS_W'(1);
                        if (os_cnt_q == OS_W'(OVERSAMPLE - 1)) begin
                            bit_tick_d = 1'b1;
                            // The bit boundary commits the deferred divisor.
                            if (state_q == PEND) begin
                                div_d   = pend_q;
                                state_d = RUN;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_baud_sched.sv
// Directed bench for uart_baud_sched with DEFAULT_DIV=4, OVERSAMPLE=16.
// Edge 0 is the rising edge that first samples en=1; outputs are sampled
// 1 time unit after each rising edge.
module tb_uart_baud_sched;

    localparam int CNT_W = 16;
    localparam int OS    = 16;
    localparam int OS_W  = 4;

    logic             clk_in = 1'b0;
    logic             rst;
    logic             en;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             resync;
    logic             os_tick;
    logic             bit_tick;
    logic [OS_W-1:0]  phase;
    logic [CNT_W-1:0] div_cur;
    logic [1:0]       dbg_state;

    int checks = 0;
    int errors = 0;

    uart_baud_sched #(
        .CNT_W(CNT_W),
        .OVERSAMPLE(OS),
        .DEFAULT_DIV(4)
    ) dut (
        .clk_in(clk_in),
        .rst(rst),
        .en(en),
        .cfg_valid(cfg_valid),
        .cfg_div(cfg_div),
        .cfg_ready(cfg_ready),
        .resync(resync),
        .os_tick(os_tick),
        .bit_tick(bit_tick),
        .phase(phase),
        .div_cur(div_cur),
        .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Reset held over one edge; reset values checked while rst is high.
    task automatic apply_reset();
        rst       = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        resync    = 1'b0;
        step();
        check("rst_os_tick", 32'(os_tick), 0);
        check("rst_bit_tick", 32'(bit_tick), 0);
        check("rst_cfg_ready", 32'(cfg_ready), 1);
        check("rst_div_cur", 32'(div_cur), 4);
        check("rst_phase", 32'(phase), 0);
        check("rst_state", 32'(dbg_state), 0);
        rst = 1'b0;
        step();
    endtask

    initial begin
        // Scenario 1: default divisor 4.
        apply_reset();
        en = 1'b1;
        step();  // edge 0
        for (int k = 1; k <= 68; k++) begin
            step();
            check("s1_os_tick", 32'(os_tick), 32'((k % 4) == 0));
            check("s1_bit_tick", 32'(bit_tick), 32'(k == 64));
            if (k == 64) begin
                check("s1_phase64", 32'(phase), 0);
                check("s1_div_cur", 32'(div_cur), 4);
            end
        end

        // Scenario 2: divisor 2 written at cycle 10, committed at edge 64.
        apply_reset();
        en = 1'b1;
        step();  // edge 0
        for (int k = 1; k <= 100; k++) begin
            if (k == 10) begin
                cfg_valid = 1'b1;
                cfg_div   = 16'd2;
            end
            step();
            if (k == 10) begin
                cfg_valid = 1'b0;
            end
            check("s2_os_tick", 32'(os_tick),
                  (k <= 64) ? 32'((k % 4) == 0) : 32'(((k - 64) % 2) == 0));
            check("s2_bit_tick", 32'(bit_tick), 32'(k == 64 || k == 96));
            check("s2_cfg_ready", 32'(cfg_ready), 32'(k < 10 || k >= 64));
            check("s2_div_cur", 32'(div_cur), (k >= 64) ? 32'd2 : 32'd4);
        end

        // Scenario 3: resync on the cycle the wrap is due.
        apply_reset();
        en = 1'b1;
        step();  // edge 0
        step();
        step();
        step();  // edge 3, cnt == 3
        resync = 1'b1;
        step();  // edge 4
        resync = 1'b0;
        check("s3_os_suppressed", 32'(os_tick), 0);
        check("s3_phase0", 32'(phase), 0);
        for (int k = 5; k <= 8; k++) begin
            step();
            check("s3_os_tick", 32'(os_tick), 32'(k == 8));
        end
        check("s3_phase1", 32'(phase), 1);

        // Scenario 4: cfg_div=0 in IDLE clamps to 1.
        apply_reset();
        cfg_valid = 1'b1;
        cfg_div   = 16'd0;
        step();
        cfg_valid = 1'b0;
        check("s4_div_cur", 32'(div_cur), 1);
        check("s4_state_idle", 32'(dbg_state), 0);
        en = 1'b1;
        step();  // edge 0
        for (int k = 1; k <= 32; k++) begin
            step();
            check("s4_os_tick", 32'(os_tick), 1);
            check("s4_bit_tick", 32'(bit_tick), 32'(k == 16 || k == 32));
        end

        // Scenario 5: pending divisor committed by en=0.
        apply_reset();
        en = 1'b1;
        step();  // edge 0
        step();
        step();
        cfg_valid = 1'b1;
        cfg_div   = 16'd5;
        step();
        cfg_valid = 1'b0;
        check("s5_pend_state", 32'(dbg_state), 2);
        check("s5_pend_ready", 32'(cfg_ready), 0);
        check("s5_pend_div", 32'(div_cur), 4);
        en = 1'b0;
        step();
        check("s5_state_idle", 32'(dbg_state), 0);
        check("s5_os_tick", 32'(os_tick), 0);
        check("s5_bit_tick", 32'(bit_tick), 0);
        check("s5_div_cur", 32'(div_cur), 5);
        check("s5_cfg_ready", 32'(cfg_ready), 1);
        check("s5_phase", 32'(phase), 0);

        // Scenario 6: en=0 with an accepted cfg in RUN writes div directly.
        en = 1'b1;
        step();  // back to RUN
        check("s6_state_run", 32'(dbg_state), 1);
        en        = 1'b0;
        cfg_valid = 1'b1;
        cfg_div   = 16'd7;
        step();
        cfg_valid = 1'b0;
        check("s6_state_idle", 32'(dbg_state), 0);
        check("s6_div_cur", 32'(div_cur), 7);

        // Scenario 7: async reset mid-bit, then restart timing.
        apply_reset();
        en = 1'b1;
        step();  // edge 0
        for (int k = 1; k <= 20; k++) begin
            step();
        end
        check("s7_pre_os_tick", 32'(os_tick), 1);
        check("s7_pre_phase", 32'(phase), 5);
        #3;
        rst = 1'b1;
        #1;
        check("s7_async_os_tick", 32'(os_tick), 0);
        check("s7_async_bit_tick", 32'(bit_tick), 0);
        check("s7_async_div", 32'(div_cur), 4);
        check("s7_async_phase", 32'(phase), 0);
        check("s7_async_state", 32'(dbg_state), 0);
        #1;
        rst = 1'b0;
        step();  // edge 0, en still high
        check("s7_restart_state", 32'(dbg_state), 1);
        for (int k = 1; k <= 8; k++) begin
            step();
            check("s7_os_tick", 32'(os_tick), 32'((k % 4) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
